// File: rtl/frame_server.sv
// Frame buffer for a block-matching estimator: byte-serial host load of a 16x16 reference
// block and a 32x32 search window, then a serve phase with three read ports.
// Optional FSERV_RDREG_EN: second read register stage (2-cycle latency), START stretched to 2 cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for the host; outputs quiet, arrays keep contents
// LOAD_REF  | accepting reference bytes 0..255
// LOAD_SRCH | accepting search window bytes 0..1023
// START     | start pulse to the estimator (two cycles with RDREG_EN)
// SERVE     | read ports live until the host releases
module frame_server (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_data,
  output logic       o_load_ready,
  input  logic       i_release,
  output logic       o_start,
  output logic       o_busy,
  input  logic [7:0] i_addressR,
  input  logic [9:0] i_addressS1,
  input  logic [9:0] i_addressS2,
  output logic [7:0] o_dataRef,
  output logic [7:0] o_dataSearch1,
  output logic [7:0] o_dataSearch2
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REF  = 3'd1,
    LOAD_SRCH = 3'd2,
    START     = 3'd3,
    SERVE     = 3'd4
  } state_t;

  state_t     state;
  state_t     stateNext;
  logic [9:0] wrCount;
  logic [9:0] wrCountNext;
  logic       refWe;
  logic       srchWe;
  logic       startPulse;
  logic       serving;

  logic [7:0] refMem  [256];
  logic [7:0] srchMem [1024];

  logic [7:0] rdRef;
  logic [7:0] rdS1;
  logic [7:0] rdS2;

`ifdef FSERV_RDREG_EN
  logic       startPhase;
  logic       startPhaseNext;
  logic [7:0] rdRef2;
  logic [7:0] rdS1b;
  logic [7:0] rdS2b;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      wrCount <= '0;
    end else begin
      state   <= stateNext;
      wrCount <= wrCountNext;
    end
  end

`ifdef FSERV_RDREG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) startPhase <= 1'b0;
    else       startPhase <= startPhaseNext;
  end
`endif

  always_comb begin
    stateNext    = state;
    wrCountNext  = wrCount;
    o_load_ready = 1'b0;
    refWe        = 1'b0;
    srchWe       = 1'b0;
    startPulse   = 1'b0;
`ifdef FSERV_RDREG_EN
    startPhaseNext = 1'b0;
`endif
    case (state)
      IDLE: begin
        // The byte that wakes us up is not consumed; it is accepted in LOAD_REF.
        wrCountNext = '0;
        if (i_load_valid) stateNext = LOAD_REF;
      end
      LOAD_REF: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          refWe = 1'b1;
          if (wrCount == 10'd255) begin
            wrCountNext = '0;
            stateNext   = LOAD_SRCH;
          end else begin
            wrCountNext = wrCount + 10'd1;
          end
        end
      end
      LOAD_SRCH: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          srchWe = 1'b1;
          if (wrCount == 10'd1023) begin
            wrCountNext = '0;
            stateNext   = START;
          end else begin
            wrCountNext = wrCount + 10'd1;
          end
        end
      end
      START: begin
`ifdef FSERV_RDREG_EN
        // Pulse lines up with the first valid data of the deeper read pipe.
        startPhaseNext = ~startPhase;
        startPulse     = startPhase;
        if (startPhase) stateNext = SERVE;
`else
        startPulse = 1'b1;
        stateNext  = SERVE;
`endif
      end
      SERVE: begin
        if (i_release) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign o_start = startPulse;
  assign o_busy  = (state != IDLE);
  assign serving = (state == START) || (state == SERVE);

  // Arrays are deliberately not reset so contents survive IDLE and reset.
  always_ff @(posedge i_clk) begin
    if (refWe)  refMem[wrCount[7:0]] <= i_load_data;
    if (srchWe) srchMem[wrCount]     <= i_load_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdRef <= '0;
      rdS1  <= '0;
      rdS2  <= '0;
    end else begin
      rdRef <= refMem[i_addressR];
      rdS1  <= srchMem[i_addressS1];
      rdS2  <= srchMem[i_addressS2];
    end
  end

`ifdef FSERV_RDREG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdRef2 <= '0;
      rdS1b  <= '0;
      rdS2b  <= '0;
    end else begin
      rdRef2 <= rdRef;
      rdS1b  <= rdS1;
      rdS2b  <= rdS2;
    end
  end

  assign o_dataRef     = serving ? rdRef2 : 8'd0;
  assign o_dataSearch1 = serving ? rdS1b  : 8'd0;
  assign o_dataSearch2 = serving ? rdS2b  : 8'd0;
`else
  // Gate by state so the cycle after release already reads zero.
  assign o_dataRef     = serving ? rdRef : 8'd0;
  assign o_dataSearch1 = serving ? rdS1  : 8'd0;
  assign o_dataSearch2 = serving ? rdS2  : 8'd0;
`endif

endmodule

// File: tb/tb_frame_server.sv
// Randomized bench for frame_server: a transaction-level model of the load/serve cycle
// is compared with the DUT on every falling edge, plus a few fixed expectations.
module tb_frame_server;

`ifdef FSERV_RDREG_EN
  localparam int LAT = 2;
  localparam int START_LEN = 2;
`else
  localparam int LAT = 1;
  localparam int START_LEN = 1;
`endif
  localparam int NBYTES = 1280;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_load_valid = 1'b0;
  logic [7:0] i_load_data = '0;
  logic       o_load_ready;
  logic       i_release = 1'b0;
  logic       o_start;
  logic       o_busy;
  logic [7:0] i_addressR = '0;
  logic [9:0] i_addressS1 = '0;
  logic [9:0] i_addressS2 = '0;
  logic [7:0] o_dataRef;
  logic [7:0] o_dataSearch1;
  logic [7:0] o_dataSearch2;

  frame_server dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_load_valid(i_load_valid), .i_load_data(i_load_data), .o_load_ready(o_load_ready),
    .i_release(i_release), .o_start(o_start), .o_busy(o_busy),
    .i_addressR(i_addressR), .i_addressS1(i_addressS1), .i_addressS2(i_addressS2),
    .o_dataRef(o_dataRef), .o_dataSearch1(o_dataSearch1), .o_dataSearch2(o_dataSearch2)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 loading (mLoaded bytes taken), 2 starting, 3 serving.
  int         mPhase = 0;
  int         mLoaded = 0;
  int         mStartLeft = 0;
  logic [7:0] refM  [256];
  logic [7:0] srchM [1024];
  logic [7:0] pR  [LAT];
  logic [7:0] pS1 [LAT];
  logic [7:0] pS2 [LAT];

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mPhase = 0;
      mLoaded = 0;
      mStartLeft = 0;
      for (int k = 0; k < LAT; k++) begin
        pR[k] = '0; pS1[k] = '0; pS2[k] = '0;
      end
    end else begin
      // Reads see the array contents from before this edge's write.
      for (int k = LAT - 1; k > 0; k--) begin
        pR[k] = pR[k-1]; pS1[k] = pS1[k-1]; pS2[k] = pS2[k-1];
      end
      pR[0]  = refM[i_addressR];
      pS1[0] = srchM[i_addressS1];
      pS2[0] = srchM[i_addressS2];
      case (mPhase)
        0: if (i_load_valid) begin mPhase = 1; mLoaded = 0; end
        1: if (i_load_valid) begin
             if (mLoaded < 256) refM[mLoaded] = i_load_data;
             else srchM[mLoaded - 256] = i_load_data;
             mLoaded++;
             if (mLoaded == NBYTES) begin mPhase = 2; mStartLeft = START_LEN; end
           end
        2: begin mStartLeft--; if (mStartLeft == 0) mPhase = 3; end
        default: if (i_release) mPhase = 0;
      endcase
    end
  end

  int readyCnt = 0;
  int startCnt = 0;

  always @(negedge i_clk) begin
    check("load_ready", int'(o_load_ready), (mPhase == 1) ? 1 : 0);
    check("busy", int'(o_busy), (mPhase != 0) ? 1 : 0);
    check("start", int'(o_start), (mPhase == 2 && mStartLeft == 1) ? 1 : 0);
    check("dataRef", int'(o_dataRef), (mPhase >= 2) ? int'(pR[LAT-1]) : 0);
    check("dataSearch1", int'(o_dataSearch1), (mPhase >= 2) ? int'(pS1[LAT-1]) : 0);
    check("dataSearch2", int'(o_dataSearch2), (mPhase >= 2) ? int'(pS2[LAT-1]) : 0);
    if (o_load_ready) readyCnt++;
    if (o_start) startCnt++;
  end

  // pat: 0 = index pattern, 1 = inverted index pattern, 2 = random
  task automatic do_load(input int pat, input int gapAt, input int rstAt, input bit rndValid);
    int idx = 0;
    int guard = 0;
    int gapLeft = 0;
    bit gapDone = 0;
    bit valid;
    bit acc;
    logic [7:0] b;
    while (idx < NBYTES && guard < 5000) begin
      b = (idx < 256) ? 8'(idx) : 8'(idx - 256);
      if (pat == 1) b = ~b;
      if (pat == 2) b = 8'($urandom);
      if (idx == rstAt) begin
        i_rst = 1'b1;
        i_load_valid = 1'b0;
        #1;
        check("rst_ready_now", int'(o_load_ready), 0);
        check("rst_busy_now", int'(o_busy), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        return;
      end
      valid = 1'b1;
      if (idx == gapAt && !gapDone) begin gapLeft = 5; gapDone = 1'b1; end
      if (gapLeft > 0) begin valid = 1'b0; gapLeft--; end
      if (rndValid && $urandom_range(0, 3) == 0) valid = 1'b0;
      i_load_valid = valid;
      i_load_data = b;
      i_release = 1'($urandom_range(0, 1));
      acc = valid && o_load_ready;
      @(posedge i_clk); #1;
      if (acc) idx++;
      guard++;
    end
    i_load_valid = 1'b0;
    i_release = 1'b0;
    check("load_complete", idx, NBYTES);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!o_start && n < 8) begin @(posedge i_clk); #1; n++; end
    check("start_seen", int'(o_start), 1);
    @(posedge i_clk); #1;
  endtask

  task automatic serve_phase(input int n, input bit lit, input bit inv);
    logic [7:0] eR, e1, e2;
    if (lit) begin
      eR = 8'h25; e1 = 8'hFF; e2 = 8'h00;
      if (inv) begin eR = ~eR; e1 = ~e1; e2 = ~e2; end
      i_addressR = 8'h25; i_addressS1 = 10'h3FF; i_addressS2 = 10'h100;
      i_load_valid = 1'b1; i_load_data = 8'hAA;
      repeat (LAT) begin @(posedge i_clk); #1; end
      check("lit_dataRef", int'(o_dataRef), int'(eR));
      check("lit_dataSearch1", int'(o_dataSearch1), int'(e1));
      check("lit_dataSearch2", int'(o_dataSearch2), int'(e2));
      check("lit_busy_serve", int'(o_busy), 1);
    end
    for (int c = 0; c < n; c++) begin
      i_addressR = 8'($urandom);
      i_addressS1 = 10'($urandom);
      i_addressS2 = ($urandom_range(0, 3) == 0) ? i_addressS1 : 10'($urandom);
      i_load_valid = 1'($urandom_range(0, 1));
      i_load_data = ($urandom_range(0, 1) == 1) ? 8'hAA : 8'($urandom);
      @(posedge i_clk); #1;
    end
    i_load_valid = 1'b0;
    i_release = 1'b1;
    @(posedge i_clk); #1;
    i_release = 1'b0;
    check("rel_busy", int'(o_busy), 0);
    check("rel_dataRef", int'(o_dataRef), 0);
    check("rel_dataSearch1", int'(o_dataSearch1), 0);
    check("rel_dataSearch2", int'(o_dataSearch2), 0);
    @(posedge i_clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_busy", int'(o_busy), 0);
    check("reset_ready", int'(o_load_ready), 0);
    check("reset_start", int'(o_start), 0);
    check("reset_dataRef", int'(o_dataRef), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    readyCnt = 0;
    startCnt = 0;
    do_load(0, -1, -1, 1'b0);
    wait_start();
    check("ready_cycles", readyCnt, NBYTES);
    check("start_pulses", startCnt, 1);
    serve_phase(300, 1'b1, 1'b0);

    do_load(0, 300, -1, 1'b0);
    wait_start();
    serve_phase(200, 1'b1, 1'b0);

    do_load(0, -1, 700, 1'b0);
    startCnt = 0;
    do_load(1, -1, -1, 1'b0);
    wait_start();
    check("start_after_reload", startCnt, 1);
    serve_phase(300, 1'b1, 1'b1);

    do_load(2, -1, -1, 1'b1);
    wait_start();
    serve_phase(400, 1'b0, 1'b0);

    repeat (3) @(posedge i_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
